// File: rtl/key_cmd_gen.sv
// key_cmd_gen: turns four debounced key levels into one-at-a-time game commands.
//
//   clk        system clock
//   clr        synchronous active-high reset; drops any command being presented
//   rotate     key level, command code 1, fires on the press only (never repeats)
//   left       key level, code 2, auto-repeats while held
//   right      key level, code 3, auto-repeats while held
//   down       key level, code 4, auto-repeats while held
//   cmd_valid  a command is presented
//   cmd_code   0 none, 1 rotate, 2 left, 3 right, 4 down
//   cmd_ready  consumer takes the presented command on this edge
//
// Build option: define KEY_SYNC_EN to put a 2-flop synchronizer on every key
// input. This adds 2 cycles of latency. Leave it undefined only when the key
// levels are already in the clk domain.
//
// Priority when several commands are pending: rotate > down > left > right.

// Delay/repeat timer for one auto-repeating key. evt_o is combinational so the
// pending bit in the parent sets on the same edge the FSM moves.
module key_rpt #(
  parameter int CNT_W      = 24,
  parameter int DELAY_CYC  = 12500000,
  parameter int REPEAT_CYC = 5000000
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic ks_i,
  input  logic rise_i,
  output logic evt_o
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} st_e;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYC - 1);

  st_e              st_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    evt_o = 1'b0;
    case (st_q)
      IDLE:    evt_o = rise_i;
      DELAY:   evt_o = ks_i && (cnt_q == DLY_LAST);
      REPEAT:  evt_o = ks_i && (cnt_q == RPT_LAST);
      default: evt_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      case (st_q)
        IDLE: if (rise_i) begin
          st_q  <= DELAY;
          cnt_q <= '0;
        end
        DELAY: if (!ks_i) begin
          st_q  <= IDLE;
          cnt_q <= '0;
        end else if (cnt_q == DLY_LAST) begin
          st_q  <= REPEAT;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        REPEAT: if (!ks_i) begin
          st_q  <= IDLE;
          cnt_q <= '0;
        end else if (cnt_q == RPT_LAST) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          st_q  <= IDLE;
          cnt_q <= '0;
        end
      endcase
    end
  end
endmodule

module key_cmd_gen #(
  parameter int CNT_W      = 24,
  parameter int DELAY_CYC  = 12500000,
  parameter int REPEAT_CYC = 5000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rotate,
  input  logic       left,
  input  logic       right,
  input  logic       down,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready
);
  // Key index i carries command code i+1: 0 rotate, 1 left, 2 right, 3 down.
  logic [3:0] raw, ks, prev_q, rise, evt;
  logic [3:0] pend_q, pend_d;
  logic       vld_q, vld_d;
  logic [2:0] code_q, code_d;

  assign raw = {down, right, left, rotate};

`ifdef KEY_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end
  assign ks = sync2_q;
`else
  assign ks = raw;
`endif

  assign rise = ks & ~prev_q;

  // Rotate only ever fires on the press.
  assign evt[0] = rise[0];

  for (genvar k = 1; k < 4; k++) begin : g_rpt
    key_rpt #(
      .CNT_W      (CNT_W),
      .DELAY_CYC  (DELAY_CYC),
      .REPEAT_CYC (REPEAT_CYC)
    ) u_rpt (
      .clk_i  (clk),
      .clr_i  (clr),
      .ks_i   (ks[k]),
      .rise_i (rise[k]),
      .evt_o  (evt[k])
    );
  end

  always_comb begin
    pend_d = pend_q;
    vld_d  = vld_q;
    code_d = code_q;
    // Load whenever the slot is empty or being taken this edge (no bubble).
    if (!vld_q || cmd_ready) begin
      vld_d  = 1'b1;
      if (pend_q[0]) begin
        code_d = 3'd1; pend_d[0] = 1'b0;
      end else if (pend_q[3]) begin
        code_d = 3'd4; pend_d[3] = 1'b0;
      end else if (pend_q[1]) begin
        code_d = 3'd2; pend_d[1] = 1'b0;
      end else if (pend_q[2]) begin
        code_d = 3'd3; pend_d[2] = 1'b0;
      end else begin
        vld_d  = 1'b0;
        code_d = 3'd0;
      end
    end
    // OR-in after the clear so an event landing on its own load edge survives.
    pend_d = pend_d | evt;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      prev_q <= '0;
      pend_q <= '0;
      vld_q  <= 1'b0;
      code_q <= 3'd0;
    end else begin
      prev_q <= ks;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      code_q <= code_d;
    end
  end

  assign cmd_valid = vld_q;
  assign cmd_code  = code_q;
endmodule

// File: tb/tb_key_cmd_gen.sv
module tb_key_cmd_gen;
  localparam int D = 8;
  localparam int R = 4;
`ifdef KEY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       rotate = 1'b0, left = 1'b0, right = 1'b0, down = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_code;

  key_cmd_gen #(.CNT_W(8), .DELAY_CYC(D), .REPEAT_CYC(R)) dut (
    .clk       (clk),
    .clr       (clr),
    .rotate    (rotate),
    .left      (left),
    .right     (right),
    .down      (down),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready)
  );

  always #5 clk = ~clk;

  // Reference model. A held key fires at hold ages 0, D, D+R, D+2R, ...
  // where age counts edges the (synchronized) level has been seen high.
  logic [3:0] m_s1, m_s2, m_ks, m_prev, m_pend, ev;
  logic       m_vld;
  logic [2:0] m_code;
  int         age [4];
  int         prio [4] = '{0, 3, 1, 2};

  always @(posedge clk) begin
    if (clr) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_pend = '0;
      m_vld = 1'b0; m_code = 3'd0;
      for (int k = 0; k < 4; k++) age[k] = 0;
    end else begin
`ifdef KEY_SYNC_EN
      m_ks = m_s2; m_s2 = m_s1; m_s1 = {down, right, left, rotate};
`else
      m_ks = {down, right, left, rotate};
`endif
      ev = '0;
      ev[0] = m_ks[0] & ~m_prev[0];
      for (int k = 1; k < 4; k++) begin
        if (m_ks[k]) begin
          age[k] = m_prev[k] ? age[k] + 1 : 0;
          ev[k] = (age[k] == 0) || (age[k] >= D && (age[k] - D) % R == 0);
        end
      end
      if (!m_vld || cmd_ready) begin
        m_vld = 1'b0; m_code = 3'd0;
        for (int i = 0; i < 4; i++) begin
          if (!m_vld && m_pend[prio[i]]) begin
            m_vld = 1'b1;
            m_code = 3'(prio[i] + 1);
            m_pend[prio[i]] = 1'b0;
          end
        end
      end
      m_pend = m_pend | ev;
      m_prev = m_ks;
    end
  end

  int   n_assert = 0;
  int   n_fail = 0;
  int   first_v;
  int   exp_n;
  logic [2:0] acc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; records the command taken on this edge, then checks
  // the outputs against the model half a cycle after the edge.
  task automatic tick();
    if (!clr && cmd_valid && cmd_ready) acc.push_back(cmd_code);
    @(negedge clk);
    chk("valid", 32'(cmd_valid), 32'(m_vld));
    chk("code", 32'(cmd_code), 32'(m_code));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int count_code(input logic [2:0] c);
    int n = 0;
    foreach (acc[i]) if (acc[i] == c) n++;
    return n;
  endfunction

  initial begin
    // Reset and idle
    @(negedge clk);
    ticks(3);
    clr = 1'b0;
    ticks(20);
    chk("idle_valid", 32'(cmd_valid), 32'd0);
    chk("idle_code", 32'(cmd_code), 32'd0);

    // Single tap on left: one command at the expected latency, no repeat
    acc.delete();
    first_v = -1;
    left = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 4) left = 1'b0;
      tick();
      if (first_v < 0 && cmd_valid) first_v = i;
    end
    chk("tap_latency", 32'(first_v), 32'(LAT + 1));
    chk("tap_count", 32'(acc.size()), 32'd1);
    chk("tap_code", 32'(count_code(3'd2)), 32'd1);

    // Auto-repeat on down held for 30 edges
    acc.delete();
    down = 1'b1;
    ticks(30);
    down = 1'b0;
    ticks(20);
    exp_n = 1 + ((30 - 1 >= D) ? (30 - 1 - D) / R + 1 : 0);
    chk("rpt_count", 32'(count_code(3'd4)), 32'(exp_n));
    chk("rpt_only_down", 32'(acc.size()), 32'(exp_n));

    // Arbitration with backpressure
    acc.delete();
    cmd_ready = 1'b0;
    {rotate, left, right, down} = 4'hf;
    ticks(2);
    {rotate, left, right, down} = 4'h0;
    ticks(LAT);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arb_hold", 32'(cmd_code), 32'd1);
    end
    cmd_ready = 1'b1;
    ticks(8);
    chk("arb_n", 32'(acc.size()), 32'd4);
    if (acc.size() == 4) begin
      chk("arb_0", 32'(acc[0]), 32'd1);
      chk("arb_1", 32'(acc[1]), 32'd4);
      chk("arb_2", 32'(acc[2]), 32'd2);
      chk("arb_3", 32'(acc[3]), 32'd3);
    end

    // Merge: output busy with left, rotate tapped twice -> one rotate
    acc.delete();
    cmd_ready = 1'b0;
    left = 1'b1; ticks(2); left = 1'b0;
    ticks(LAT + 2);
    for (int j = 0; j < 2; j++) begin
      rotate = 1'b1; ticks(2);
      rotate = 1'b0; ticks(3);
    end
    ticks(LAT);
    cmd_ready = 1'b1;
    ticks(8);
    chk("merge_rot", 32'(count_code(3'd1)), 32'd1);
    chk("merge_left", 32'(count_code(3'd2)), 32'd1);

    // Set-wins: hold right with random-free stalls so repeats collide with loads
    acc.delete();
    right = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cmd_ready = (i % 3 != 0);
      tick();
    end
    right = 1'b0;
    cmd_ready = 1'b1;
    ticks(10);

    // Reset mid-operation: right in REPEAT, command stalled, then clr
    right = 1'b1;
    ticks(20);
    cmd_ready = 1'b0;
    first_v = 0;
    for (int i = 0; i < 20 && !cmd_valid; i++) tick();
    chk("mid_stalled", 32'(cmd_valid), 32'd1);
    clr = 1'b1;
    tick();
    chk("mid_clr_valid", 32'(cmd_valid), 32'd0);
    clr = 1'b0;
    cmd_ready = 1'b1;
    ticks(15);
    right = 1'b0;
    ticks(10);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) rotate = ~rotate;
      if ($urandom_range(7) == 0) left   = ~left;
      if ($urandom_range(7) == 0) right  = ~right;
      if ($urandom_range(7) == 0) down   = ~down;
      cmd_ready = ($urandom_range(3) != 0);
      clr = ($urandom_range(199) == 0);
      tick();
    end
    clr = 1'b0;
    {rotate, left, right, down} = 4'h0;
    cmd_ready = 1'b1;
    ticks(12);
    chk("drain_valid", 32'(cmd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
